pacman_motion_ctrl: RTL and testbench

- Per-frame motion sequencer for the Pac-Man sprite.
- Sits between keypad inputs, the collision detector and the Pac-Man bitmap/square-object pair.
- Buffers turn requests and checks wall hits against the bitmap's edge code, then updates sprite position once per frame.
- Drives the bitmap's direction and mouth frame, and handles tunnel wrap and the death/respawn sequence.

---
 rtl/pacman_motion_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man motion sequencer: turn requests, wall push-back, tunnel wrap and death/respawn, updated once per frame.
// Build option: define PACMAN_TURN_BUFFER_EN to keep a turn request alive for TURN_HOLD frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | parked, waiting for enable plus a turn request
// MOVING  | advancing SPEED pixels per frame in the current direction
// BLOCKED | pushed back off a wall, waiting for an open turn
// DYING   | death animation, counts DEATH_FRAMES frames, then respawns
module pacman_motion_ctrl #(
    parameter int INIT_X       = 288,
    parameter int INIT_Y       = 208,
    parameter int SPEED        = 2,
    parameter int SCREEN_W     = 640,
    parameter int SPRITE_W     = 32,
    parameter int TURN_HOLD    = 8,
    parameter int ANIM_FRAMES  = 4,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        startOfFrame,
    input  logic        keyUp,
    input  logic        keyDown,
    input  logic        keyLeft,
    input  logic        keyRight,
    input  logic        collisionWall,
    input  logic [3:0]  HitEdgeCode,
    input  logic        pacmanDies,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  direction,
    output logic        mouthFrame,
    output logic        dying,
    output logic        moving
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVING  = 2'd1,
        S_BLOCKED = 2'd2,
        S_DYING   = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int ANIM_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DEATH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_FRAMES - 1);
    localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_FRAMES - 1);
    localparam logic [10:0]        SPD        = 11'(SPEED);
    localparam logic [10:0]        WRAP_X     = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0]        HOME_X     = 11'(INIT_X);
    localparam logic [10:0]        HOME_Y     = 11'(INIT_Y);

    function automatic logic [3:0] edge_mask(input logic [1:0] d);
        logic [3:0] m;
        case (d)
            DIR_UP:   m = 4'b0100;
            DIR_DOWN: m = 4'b0001;
            DIR_LEFT: m = 4'b1000;
            default:  m = 4'b0010;
        endcase
        return m;
    endfunction

    state_t             state, state_nxt;
    logic [10:0]        x_nxt, y_nxt;
    logic [1:0]         dir_nxt;
    logic               mouth_nxt;
    logic [ANIM_W-1:0]  anim_cnt, anim_nxt;
    logic [DEATH_W-1:0] death_cnt, death_nxt;
    logic [3:0]         blocked_edges, edges_nxt, frame_edges;

    logic               key_any;
    logic [1:0]         key_dir;
    logic               req_valid;
    logic [1:0]         req_dir;
    logic               turn_ok;
    logic [1:0]         cur_dir, move_dir;
    logic               do_move;

    always_comb begin
        key_any = keyUp | keyDown | keyLeft | keyRight;
        if (keyUp)        key_dir = DIR_UP;
        else if (keyDown) key_dir = DIR_DOWN;
        else if (keyLeft) key_dir = DIR_LEFT;
        else              key_dir = DIR_RIGHT;
    end

`ifdef PACMAN_TURN_BUFFER_EN
    localparam int                HOLD_W    = $clog2(TURN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TURN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              pend_valid, pend_valid_nxt;
    logic [1:0]        pend_dir, pend_dir_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    // A key held in the frame cycle itself counts as the freshest request.
    always_comb begin
        req_valid = (key_any && state != S_DYING) || pend_valid;
        req_dir   = (key_any && state != S_DYING) ? key_dir : pend_dir;
    end
`else
    always_comb begin
        req_valid = key_any;
        req_dir   = key_dir;
    end
`endif

    always_comb begin
        state_nxt   = state;
        x_nxt       = topLeftX;
        y_nxt       = topLeftY;
        dir_nxt     = direction;
        mouth_nxt   = mouthFrame;
        anim_nxt    = anim_cnt;
        death_nxt   = death_cnt;
        cur_dir     = direction;
        move_dir    = direction;
        do_move     = 1'b0;
`ifdef PACMAN_TURN_BUFFER_EN
        pend_valid_nxt = pend_valid;
        pend_dir_nxt   = pend_dir;
        hold_nxt       = hold_cnt;
`endif
        // Edges seen this frame include a hit landing in the frame cycle itself.
        frame_edges = blocked_edges | (collisionWall ? HitEdgeCode : 4'h0);
        edges_nxt   = startOfFrame ? 4'h0 : frame_edges;
        turn_ok     = req_valid && ((frame_edges & edge_mask(req_dir)) == 4'h0);

        if (pacmanDies && !(state == S_IDLE && !enable)) begin
            state_nxt = S_DYING;
            death_nxt = '0;
        end else if (!enable && (state == S_MOVING || state == S_BLOCKED)) begin
            state_nxt = S_IDLE;
        end else if (startOfFrame) begin
            case (state)
                S_IDLE: begin
                    if (enable && req_valid) begin
                        state_nxt = S_MOVING;
                        dir_nxt   = req_dir;
`ifdef PACMAN_TURN_BUFFER_EN
                        pend_valid_nxt = 1'b0;
`endif
                    end
                end
                S_MOVING: begin
                    if (turn_ok) begin
                        cur_dir = req_dir;
`ifdef PACMAN_TURN_BUFFER_EN
                        pend_valid_nxt = 1'b0;
                    end else if (pend_valid) begin
                        hold_nxt = hold_cnt - HOLD_ONE;
                        if (hold_cnt == HOLD_ONE) pend_valid_nxt = 1'b0;
`endif
                    end
                    dir_nxt = cur_dir;
                    do_move = 1'b1;
                    if ((frame_edges & edge_mask(cur_dir)) != 4'h0) begin
                        move_dir  = {cur_dir[1], ~cur_dir[0]};
                        state_nxt = S_BLOCKED;
                        mouth_nxt = 1'b0;
                        anim_nxt  = '0;
                    end else begin
                        move_dir = cur_dir;
                        if (anim_cnt == ANIM_LAST) begin
                            mouth_nxt = ~mouthFrame;
                            anim_nxt  = '0;
                        end else begin
                            anim_nxt = anim_cnt + 1'b1;
                        end
                    end
                end
                S_BLOCKED: begin
                    mouth_nxt = 1'b0;
                    if (turn_ok) begin
                        dir_nxt   = req_dir;
                        state_nxt = S_MOVING;
`ifdef PACMAN_TURN_BUFFER_EN
                        pend_valid_nxt = 1'b0;
                    end else if (pend_valid) begin
                        hold_nxt = hold_cnt - HOLD_ONE;
                        if (hold_cnt == HOLD_ONE) pend_valid_nxt = 1'b0;
`endif
                    end
                end
                S_DYING: begin
                    if (death_cnt == DEATH_LAST) begin
                        state_nxt = S_IDLE;
                        x_nxt     = HOME_X;
                        y_nxt     = HOME_Y;
                        dir_nxt   = DIR_RIGHT;
                        mouth_nxt = 1'b0;
                        anim_nxt  = '0;
`ifdef PACMAN_TURN_BUFFER_EN
                        pend_valid_nxt = 1'b0;
`endif
                    end else begin
                        death_nxt = death_cnt + 1'b1;
                    end
                end
            endcase
        end

        if (do_move) begin
            case (move_dir)
                DIR_UP:   y_nxt = topLeftY - SPD;
                DIR_DOWN: y_nxt = topLeftY + SPD;
                DIR_LEFT: x_nxt = (topLeftX < SPD) ? WRAP_X : topLeftX - SPD;
                default:  x_nxt = (topLeftX >= WRAP_X) ? 11'd0 : topLeftX + SPD;
            endcase
        end

`ifdef PACMAN_TURN_BUFFER_EN
        if (key_any && state != S_DYING) begin
            pend_valid_nxt = 1'b1;
            pend_dir_nxt   = key_dir;
            hold_nxt       = HOLD_LOAD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            topLeftX      <= HOME_X;
            topLeftY      <= HOME_Y;
            direction     <= DIR_RIGHT;
            mouthFrame    <= 1'b0;
            anim_cnt      <= '0;
            death_cnt     <= '0;
            blocked_edges <= 4'h0;
`ifdef PACMAN_TURN_BUFFER_EN
            pend_valid    <= 1'b0;
            pend_dir      <= DIR_RIGHT;
            hold_cnt      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            topLeftX      <= x_nxt;
            topLeftY      <= y_nxt;
            direction     <= dir_nxt;
            mouthFrame    <= mouth_nxt;
            anim_cnt      <= anim_nxt;
            death_cnt     <= death_nxt;
            blocked_edges <= edges_nxt;
`ifdef PACMAN_TURN_BUFFER_EN
            pend_valid    <= pend_valid_nxt;
            pend_dir      <= pend_dir_nxt;
            hold_cnt      <= hold_nxt;
`endif
        end
    end

    assign dying  = (state == S_DYING);
    assign moving = (state == S_MOVING);

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Directed bench for pacman_motion_ctrl: start-up, wall push-back, turns, tunnel wrap, death and reset abort.
module tb_pacman_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        startOfFrame;
    logic        keyUp, keyDown, keyLeft, keyRight;
    logic        collisionWall;
    logic [3:0]  HitEdgeCode;
    logic        pacmanDies;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [1:0]  direction;
    logic        mouthFrame;
    logic        dying;
    logic        moving;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x;
    int exp_y;

    pacman_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .startOfFrame (startOfFrame),
        .keyUp        (keyUp),
        .keyDown      (keyDown),
        .keyLeft      (keyLeft),
        .keyRight     (keyRight),
        .collisionWall(collisionWall),
        .HitEdgeCode  (HitEdgeCode),
        .pacmanDies   (pacmanDies),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .direction    (direction),
        .mouthFrame   (mouthFrame),
        .dying        (dying),
        .moving       (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: strobe cycle (optionally with a wall hit), then one quiet cycle.
    task automatic frame(input logic [3:0] code);
        startOfFrame  = 1'b1;
        collisionWall = (code != 4'h0);
        HitEdgeCode   = code;
        tick();
        startOfFrame  = 1'b0;
        collisionWall = 1'b0;
        HitEdgeCode   = 4'h0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(topLeftX), 288);
        check({tag, "_y"}, 32'(topLeftY), 208);
        check({tag, "_dir"}, 32'(direction), 3);
        check({tag, "_mouth"}, 32'(mouthFrame), 0);
        check({tag, "_dying"}, 32'(dying), 0);
        check({tag, "_moving"}, 32'(moving), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0;
        keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
        collisionWall = 1'b0; HitEdgeCode = 4'h0; pacmanDies = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b0;

        // Death pulse ignored while idle and disabled
        pacmanDies = 1'b1; tick(); pacmanDies = 1'b0;
        check("die_idle_disabled", 32'(dying), 0);
        enable = 1'b1; tick();

        // Start moving right; start frame does not move
        keyRight = 1'b1; frame(4'h0); keyRight = 1'b0;
        check("start_moving", 32'(moving), 1);
        check("start_dir", 32'(direction), 3);
        check("start_x", 32'(topLeftX), 288);
        exp_x = 288;
        for (int i = 0; i < 3; i++) begin
            frame(4'h0);
            exp_x += 2;
            check("advance_x", 32'(topLeftX), 32'(exp_x));
        end
        check("mouth_open", 32'(mouthFrame), 0);
        frame(4'h0);
        check("advance_x4", 32'(topLeftX), 296);
        check("mouth_toggle", 32'(mouthFrame), 1);
        repeat (3) tick();
        check("hold_between_frames", 32'(topLeftX), 296);

        // Right edge hit mid-frame, consumed at the next strobe
        collisionWall = 1'b1; HitEdgeCode = 4'h2; tick();
        collisionWall = 1'b0; HitEdgeCode = 4'h0; tick();
        frame(4'h0);
        check("pushback_x", 32'(topLeftX), 294);
        check("blocked_moving", 32'(moving), 0);
        check("blocked_mouth", 32'(mouthFrame), 0);
        check("blocked_dir", 32'(direction), 3);
        frame(4'h0);
        check("blocked_hold_x", 32'(topLeftX), 294);

        // Turn up out of BLOCKED
        keyUp = 1'b1; frame(4'h0); keyUp = 1'b0;
        check("unblock_dir", 32'(direction), 0);
        check("unblock_moving", 32'(moving), 1);
        check("unblock_y", 32'(topLeftY), 208);
        frame(4'h0);
        exp_y = 206;
        check("up_y", 32'(topLeftY), 32'(exp_y));

`ifndef PACMAN_TURN_BUFFER_EN
        // Unbuffered: a turn into a wall is dropped
        keyLeft = 1'b1; frame(4'h8); keyLeft = 1'b0;
        exp_y = 204;
        check("drop_dir", 32'(direction), 0);
        check("drop_y", 32'(topLeftY), 32'(exp_y));
        frame(4'h0);
        exp_y = 202;
        check("drop_stays_dir", 32'(direction), 0);
`endif

        // Tunnel wrap going left, then right
        keyLeft = 1'b1; frame(4'h0); keyLeft = 1'b0;
        check("left_dir", 32'(direction), 2);
        check("left_x", 32'(topLeftX), 292);
        repeat (146) frame(4'h0);
        check("left_reach0", 32'(topLeftX), 0);
        check("left_y_kept", 32'(topLeftY), 32'(exp_y));
        frame(4'h0);
        check("wrap_left", 32'(topLeftX), 608);
        keyRight = 1'b1; frame(4'h0); keyRight = 1'b0;
        check("wrap_right_dir", 32'(direction), 3);
        check("wrap_right", 32'(topLeftX), 0);
        exp_x = 0;

`ifdef PACMAN_TURN_BUFFER_EN
        // Buffered turn survives 3 blocked frames
        keyUp = 1'b1; tick(); keyUp = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            frame(4'h4);
            exp_x += 2;
            check("buf_wait_dir", 32'(direction), 3);
        end
        frame(4'h0);
        exp_y -= 2;
        check("buf_turn_dir", 32'(direction), 0);
        check("buf_turn_y", 32'(topLeftY), 32'(exp_y));
        check("buf_turn_x", 32'(topLeftX), 32'(exp_x));
        keyRight = 1'b1; frame(4'h0); keyRight = 1'b0;
        exp_x += 2;
        check("buf_back_right", 32'(topLeftX), 32'(exp_x));
        // Expires after 9 blocked frames
        keyUp = 1'b1; tick(); keyUp = 1'b0; tick();
        repeat (9) begin
            frame(4'h4);
            exp_x += 2;
        end
        frame(4'h0);
        exp_x += 2;
        check("buf_expired_dir", 32'(direction), 3);
        check("buf_expired_x", 32'(topLeftX), 32'(exp_x));
`endif

        // Death coincident with a frame strobe
        pacmanDies = 1'b1; startOfFrame = 1'b1; tick();
        pacmanDies = 1'b0; startOfFrame = 1'b0; tick();
        check("die_dying", 32'(dying), 1);
        check("die_moving", 32'(moving), 0);
        check("die_frozen_x", 32'(topLeftX), 32'(exp_x));
        repeat (59) frame(4'h0);
        check("dying_59", 32'(dying), 1);
        check("dying_59_x", 32'(topLeftX), 32'(exp_x));
        frame(4'h0);
        check_reset_values("respawn");
        frame(4'h0);
        check("idle_hold", 32'(moving), 0);

        // enable drop returns to IDLE holding position
        keyRight = 1'b1; frame(4'h0); keyRight = 1'b0;
        frame(4'h0);
        check("restart_x", 32'(topLeftX), 290);
        keyUp = 1'b1; frame(4'h0); keyUp = 1'b0;
        check("restart_up_y", 32'(topLeftY), 206);
        enable = 1'b0; tick();
        check("disable_idle", 32'(moving), 0);
        frame(4'h0);
        check("disable_hold_y", 32'(topLeftY), 206);
        enable = 1'b1;
        keyUp = 1'b1; frame(4'h0); keyUp = 1'b0;
        check("reenable_moving", 32'(moving), 1);
        check("reenable_y", 32'(topLeftY), 206);

        // Reset aborts DYING
        pacmanDies = 1'b1; tick(); pacmanDies = 1'b0;
        check("die2_dying", 32'(dying), 1);
        repeat (30) frame(4'h0);
        reset = 1'b1; tick();
        check_reset_values("rst_dying");
        reset = 1'b0; tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
